// File: rtl/quad_pkg.sv
// rtl/quad_pkg.sv - Gray-code state and direction constants for the quadrature decoder
package quad_pkg;

    localparam logic [1:0] Q00 = 2'b00;
    localparam logic [1:0] Q01 = 2'b01;
    localparam logic [1:0] Q11 = 2'b11;
    localparam logic [1:0] Q10 = 2'b10;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

    function automatic logic [1:0] next_fwd(input logic [1:0] state);
        logic [1:0] nxt;
        case (state)
            Q00:     nxt = Q01;
            Q01:     nxt = Q11;
            Q11:     nxt = Q10;
            default: nxt = Q00;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/quad_filter.sv
// rtl/quad_filter.sv - AB synchronizer and glitch filter producing an accept strobe
module quad_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic       clk,
    input  logic       rst_n_a,
    input  logic [1:0] ab_in,
    output logic [1:0] acc,
    output logic [1:0] cand,
    output logic       accept
);
    import quad_pkg::*;

    localparam int STAB_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(FILT_LEN - 1);

    logic [SYNC_STAGES-1:0][1:0] sync_q, sync_d;
    logic [1:0]                  cand_q, cand_d;
    logic [1:0]                  acc_q, acc_d;
    logic [STAB_W-1:0]           stab_q, stab_d;
    logic [1:0]                  s_ab;
    logic                        accept_c;

    assign s_ab = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d[0] = ab_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // Accept is combinational so acc and the decoder outputs land on the same edge.
    assign accept_c = (s_ab == cand_q) && (stab_q == STAB_MAX) && (cand_q != acc_q);

    always_comb begin
        cand_d = cand_q;
        stab_d = stab_q;
        acc_d  = acc_q;
        if (s_ab != cand_q) begin
            cand_d = s_ab;
            stab_d = '0;
        end else if (stab_q < STAB_MAX) begin
            stab_d = stab_q + STAB_W'(1);
        end
        if (accept_c) begin
            acc_d = cand_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n_a) begin
        if (!rst_n_a) begin
            sync_q <= '0;
            cand_q <= Q00;
            acc_q  <= Q00;
            stab_q <= '0;
        end else begin
            sync_q <= sync_d;
            cand_q <= cand_d;
            acc_q  <= acc_d;
            stab_q <= stab_d;
        end
    end

    assign acc    = acc_q;
    assign cand   = cand_q;
    assign accept = accept_c;

endmodule

// File: rtl/quad_decoder.sv
// rtl/quad_decoder.sv - Quadrature decoder with step/dir pulses, wrapping position and sticky error
module quad_decoder #(
    parameter int POS_MAX     = 256,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic                       clk,
    input  logic                       rst_n_a,
    input  logic                       quad_a,
    input  logic                       quad_b,
    input  logic                       en,
    input  logic                       clr,
    input  logic                       err_clr,
    output logic                       step,
    output logic                       dir,
    output logic [$clog2(POS_MAX)-1:0] position,
    output logic                       err
);
    import quad_pkg::*;

    localparam int POS_W = $clog2(POS_MAX);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(POS_MAX - 1);

    logic [1:0]       acc, cand;
    logic             accept;
    logic             primed_q, primed_d;
    logic             step_q, step_d;
    logic             dir_q, dir_d;
    logic             err_q, err_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             is_fwd, is_rev;

    quad_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_LEN    (FILT_LEN)
    ) u_filter (
        .clk     (clk),
        .rst_n_a (rst_n_a),
        .ab_in   ({quad_a, quad_b}),
        .acc     (acc),
        .cand    (cand),
        .accept  (accept)
    );

    assign is_fwd = (next_fwd(acc) == cand);
    assign is_rev = (next_fwd(cand) == acc);

    always_comb begin
        primed_d = primed_q;
        step_d   = 1'b0;
        dir_d    = dir_q;
        err_d    = err_q;
        pos_d    = pos_q;
        if (err_clr) begin
            err_d = 1'b0;
        end
        if (accept) begin
            if (!primed_q) begin
                primed_d = 1'b1;
            end else if (is_fwd) begin
                step_d = 1'b1;
                dir_d  = DIR_FWD;
                if (en) begin
                    pos_d = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);
                end
            end else if (is_rev) begin
                step_d = 1'b1;
                dir_d  = DIR_REV;
                if (en) begin
                    pos_d = (pos_q == '0) ? POS_LAST : pos_q - POS_W'(1);
                end
            end else begin
                // Both bits flipped: direction is unknowable, so flag it and skip the step.
                err_d = 1'b1;
            end
        end
        if (clr) begin
            pos_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n_a) begin
        if (!rst_n_a) begin
            primed_q <= 1'b0;
            step_q   <= 1'b0;
            dir_q    <= DIR_FWD;
            err_q    <= 1'b0;
            pos_q    <= '0;
        end else begin
            primed_q <= primed_d;
            step_q   <= step_d;
            dir_q    <= dir_d;
            err_q    <= err_d;
            pos_q    <= pos_d;
        end
    end

    assign step     = step_q;
    assign dir      = dir_q;
    assign err      = err_q;
    assign position = pos_q;

endmodule

// File: tb/tb_quad_decoder.sv
// tb/tb_quad_decoder.sv - Directed self-checking bench for quad_decoder
module tb_quad_decoder;

    logic       clk = 1'b0;
    logic       rst_n_a = 1'b0;
    logic       quad_a = 1'b0;
    logic       quad_b = 1'b0;
    logic       en = 1'b1;
    logic       clr = 1'b0;
    logic       err_clr = 1'b0;
    logic       step;
    logic       dir;
    logic [7:0] position;
    logic       err;

    int tests = 0;
    int fails = 0;

    logic [1:0] fwd_seq [4] = '{2'b01, 2'b11, 2'b10, 2'b00};

    always #5 clk = ~clk;

    quad_decoder #(.POS_MAX(256), .SYNC_STAGES(2), .FILT_LEN(4)) dut (
        .clk      (clk),
        .rst_n_a  (rst_n_a),
        .quad_a   (quad_a),
        .quad_b   (quad_b),
        .en       (en),
        .clr      (clr),
        .err_clr  (err_clr),
        .step     (step),
        .dir      (dir),
        .position (position),
        .err      (err)
    );

    // Drives pins, runs a fixed number of edges, reports step count and the edge of the first step.
    task automatic watch(input logic [1:0] ab, input int cycles, input int clr_at,
                         input int eclr_at, output int nsteps, output int first);
        {quad_a, quad_b} = ab;
        nsteps = 0;
        first  = 0;
        for (int i = 1; i <= cycles; i++) begin
            clr     = (i == clr_at);
            err_clr = (i == eclr_at);
            @(posedge clk);
            #1;
            if (step) begin
                nsteps++;
                if (first == 0) first = i;
            end
        end
        clr     = 1'b0;
        err_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n_a = 1'b0;
        {quad_a, quad_b} = 2'b00;
        #23;
        tests++;
        if ({step, dir, position, err} !== 11'd0) begin
            fails++;
            $display("FAIL reset_outputs: got step=%b dir=%b pos=%0d err=%b, want all 0", step, dir, position, err);
        end
        @(negedge clk);
        rst_n_a = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_forward();
        int n, f;
        watch(2'b01, 12, 0, 0, n, f);
        tests++;
        if (n !== 0 || err !== 1'b0) begin
            fails++;
            $display("FAIL prime_no_step: got steps=%0d err=%b, want 0 0", n, err);
        end
        watch(2'b00, 12, 0, 0, n, f);
        tests++;
        if (n !== 1 || f !== 7 || dir !== 1'b1 || position !== 8'd255) begin
            fails++;
            $display("FAIL first_reverse: got steps=%0d edge=%0d dir=%b pos=%0d, want 1 7 1 255", n, f, dir, position);
        end
        watch(2'b00, 2, 1, 0, n, f);
        tests++;
        if (position !== 8'd0) begin
            fails++;
            $display("FAIL clr_to_zero: got pos=%0d, want 0", position);
        end
        for (int k = 0; k < 4; k++) begin
            watch(fwd_seq[k], 10, 0, 0, n, f);
            tests++;
            if (n !== 1 || f !== 7 || dir !== 1'b0 || position !== 8'(k + 1)) begin
                fails++;
                $display("FAIL fwd_step%0d: got steps=%0d edge=%0d dir=%b pos=%0d, want 1 7 0 %0d", k, n, f, dir, position, k + 1);
            end
        end
    endtask

    task automatic test_glitch();
        int n1, n2, f;
        watch(2'b10, 2, 0, 0, n1, f);
        watch(2'b00, 15, 0, 0, n2, f);
        tests++;
        if (n1 + n2 !== 0 || position !== 8'd4 || err !== 1'b0) begin
            fails++;
            $display("FAIL glitch_reject: got steps=%0d pos=%0d err=%b, want 0 4 0", n1 + n2, position, err);
        end
        watch(2'b10, 12, 0, 0, n1, f);
        tests++;
        if (n1 !== 1 || dir !== 1'b1 || position !== 8'd3) begin
            fails++;
            $display("FAIL glitch_held: got steps=%0d dir=%b pos=%0d, want 1 1 3", n1, dir, position);
        end
        watch(2'b00, 12, 0, 0, n1, f);
        tests++;
        if (n1 !== 1 || dir !== 1'b0 || position !== 8'd4) begin
            fails++;
            $display("FAIL glitch_return: got steps=%0d dir=%b pos=%0d, want 1 0 4", n1, dir, position);
        end
    endtask

    task automatic test_reverse_wrap();
        int n, f;
        watch(2'b00, 2, 1, 0, n, f);
        watch(2'b10, 12, 0, 0, n, f);
        tests++;
        if (n !== 1 || dir !== 1'b1 || position !== 8'd255) begin
            fails++;
            $display("FAIL rev_wrap: got steps=%0d dir=%b pos=%0d, want 1 1 255", n, dir, position);
        end
        watch(2'b11, 12, 0, 0, n, f);
        tests++;
        if (n !== 1 || dir !== 1'b1 || position !== 8'd254) begin
            fails++;
            $display("FAIL rev_254: got steps=%0d dir=%b pos=%0d, want 1 1 254", n, dir, position);
        end
    endtask

    task automatic test_illegal();
        int n, f;
        watch(2'b10, 12, 0, 0, n, f);
        watch(2'b00, 12, 0, 0, n, f);
        tests++;
        if (position !== 8'd0 || dir !== 1'b0) begin
            fails++;
            $display("FAIL fwd_wrap: got pos=%0d dir=%b, want 0 0", position, dir);
        end
        watch(2'b11, 12, 0, 0, n, f);
        tests++;
        if (n !== 0 || err !== 1'b1 || position !== 8'd0 || dir !== 1'b0) begin
            fails++;
            $display("FAIL illegal_00_11: got steps=%0d err=%b pos=%0d dir=%b, want 0 1 0 0", n, err, position, dir);
        end
        watch(2'b11, 3, 0, 1, n, f);
        tests++;
        if (err !== 1'b0) begin
            fails++;
            $display("FAIL err_clr: got err=%b, want 0", err);
        end
        watch(2'b00, 12, 0, 7, n, f);
        tests++;
        if (n !== 0 || err !== 1'b1) begin
            fails++;
            $display("FAIL err_set_wins: got steps=%0d err=%b, want 0 1", n, err);
        end
        watch(2'b00, 3, 0, 1, n, f);
        tests++;
        if (err !== 1'b0) begin
            fails++;
            $display("FAIL err_clr2: got err=%b, want 0", err);
        end
    endtask

    task automatic test_clr_en();
        int n, f, total;
        for (int k = 0; k < 10; k++) watch(fwd_seq[k % 4], 10, 0, 0, n, f);
        tests++;
        if (position !== 8'd10) begin
            fails++;
            $display("FAIL reach_10: got pos=%0d, want 10", position);
        end
        en = 1'b0;
        total = 0;
        for (int k = 2; k < 6; k++) begin
            watch(fwd_seq[k % 4], 10, 0, 0, n, f);
            total += n;
        end
        tests++;
        if (total !== 4 || position !== 8'd10) begin
            fails++;
            $display("FAIL en_low: got steps=%0d pos=%0d, want 4 10", total, position);
        end
        en = 1'b1;
        watch(fwd_seq[2], 10, 7, 0, n, f);
        tests++;
        if (n !== 1 || f !== 7 || position !== 8'd0 || dir !== 1'b0) begin
            fails++;
            $display("FAIL clr_wins: got steps=%0d edge=%0d pos=%0d dir=%b, want 1 7 0 0", n, f, position, dir);
        end
    endtask

    task automatic test_reset_mid_run();
        int n, f;
        for (int k = 0; k < 36; k++) watch(fwd_seq[(3 + k) % 4], 10, 0, 0, n, f);
        watch(fwd_seq[3], 6, 0, 0, n, f);
        @(posedge clk);
        #3;
        tests++;
        if (step !== 1'b1 || position !== 8'd37) begin
            fails++;
            $display("FAIL pre_reset: got step=%b pos=%0d, want 1 37", step, position);
        end
        rst_n_a = 1'b0;
        #1;
        tests++;
        if (step !== 1'b0 || position !== 8'd0 || err !== 1'b0 || dir !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: got step=%b pos=%0d err=%b dir=%b, want 0 0 0 0", step, position, err, dir);
        end
        {quad_a, quad_b} = 2'b11;
        #20;
        @(negedge clk);
        rst_n_a = 1'b1;
        @(posedge clk);
        #1;
        watch(2'b11, 15, 0, 0, n, f);
        tests++;
        if (n !== 0 || err !== 1'b0 || position !== 8'd0) begin
            fails++;
            $display("FAIL reprime: got steps=%0d err=%b pos=%0d, want 0 0 0", n, err, position);
        end
        watch(2'b10, 12, 0, 0, n, f);
        tests++;
        if (n !== 1 || f !== 7 || position !== 8'd1 || dir !== 1'b0) begin
            fails++;
            $display("FAIL post_prime_step: got steps=%0d edge=%0d pos=%0d dir=%b, want 1 7 1 0", n, f, position, dir);
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_glitch();
        test_reverse_wrap();
        test_illegal();
        test_clr_en();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
